async_fifo_wr_ctrl: RTL and testbench
=====================================

Name: async_fifo_wr_ctrl

Overview:
- Write-domain half of the team's dual-clock FIFO. It is the responder to a producer that writes one byte per wr_clk.
- Accepts wr_en/din, drives the dual-port RAM write port, and keeps a Gray-coded write pointer for the read domain.
- Synchronizes the read domain's Gray pointer into wr_clk to generate full, almost_full, wr_ack and overflow.
- Pairs with a matching read-domain controller; RAM is external.

Parameters:
- DATA_WIDTH, 8: width of din and mem_wdata.
- ADDR_WIDTH, 4: RAM address width; depth = 2^ADDR_WIDTH (16).
- SYNC_STAGES, 2: flop stages on rd_ptr_gray into wr_clk; legal range 2..4.
- ALMOST_FULL_THRESH, 14: occupancy at or above which almost_full asserts; legal range 1..depth.

Ports:
- wr_clk, in, 1: write-domain clock.
- rst, in, 1: reset, asynchronous, active-high.
- wr_en, in, 1: write request.
- din, in, DATA_WIDTH: write data.
- full, out, 1: FIFO full; writes ignored while high.
- almost_full, out, 1: occupancy >= ALMOST_FULL_THRESH.
- wr_ack, out, 1: previous-cycle write accepted.
- overflow, out, 1: previous-cycle write rejected (full).
- rd_ptr_gray, in, ADDR_WIDTH+1: read pointer, Gray, from rd_clk domain (asynchronous).
- wr_ptr_gray, out, ADDR_WIDTH+1: write pointer, Gray, registered, to read domain.
- mem_we, out, 1: RAM write enable.
- mem_waddr, out, ADDR_WIDTH: RAM write address.
- mem_wdata, out, DATA_WIDTH: RAM write data.

Behaviour:
- Reset is rst, asynchronous, active-high; clock is wr_clk.
- Values while rst is high:
  - wr_bin, wr_ptr_gray and all sync flops: 0.
  - full: 1.
  - almost_full, wr_ack, overflow: 0.
- Reset release: full clears to 0 on the first wr_clk rising edge after rst falls. No write is accepted on that edge, because full was 1.
- Accept condition: accept = wr_en & ~full.
- RAM write port (combinational, same cycle):
  - mem_we = accept.
  - mem_waddr = wr_bin[ADDR_WIDTH-1:0].
  - mem_wdata = din.
- Pointer update: on an accepted edge, wr_bin increments by 1 modulo 2^(ADDR_WIDTH+1). wr_ptr_gray = registered bin2gray of the next wr_bin, so exactly one bit changes per increment.
- Read pointer sync: rd_ptr_gray passes through SYNC_STAGES flops to give rq_gray, then gray2bin gives rq_bin.
- full: registered. Next value is 1 when next_wr_gray equals rq_gray with its two MSBs inverted and the remaining bits equal.
- almost_full: registered. Next value is 1 when (next_wr_bin - rq_bin) mod 2^(ADDR_WIDTH+1) >= ALMOST_FULL_THRESH.
- wr_ack: registered copy of accept; 1-cycle pulse per accepted write.
- overflow: registered (wr_en & full); 1-cycle pulse per rejected write.
- A rejected write changes neither pointer nor RAM.
- Flag timing with the read side:
  - full and almost_full are conservative.
  - Assertion is immediate on the edge that fills the FIFO.
  - Deassertion lags a read-pointer change by SYNC_STAGES+1 wr_clk edges.
  - A simultaneous read and write on the full boundary never over-writes.
- Wrap-around: the extra MSB distinguishes full from empty; address wraps 15->0 at the default depth.
- Reset mid-burst: everything returns to reset values immediately; the in-flight write is dropped.

Optional Feature:
- Macro: WR_DATA_COUNT_EN.
- Defined: adds output port wr_data_count [ADDR_WIDTH:0].
  - Registered value of (next_wr_bin - rq_bin); range 0..2^ADDR_WIDTH.
  - Reset value 0.
  - Same lag as almost_full.
- Undefined: port and its subtractor logic are absent.
- almost_full behaviour is identical in both builds.

Test Plan:
- Reset: rst high 50 ns -> full=1, almost_full=0, wr_ack=0, overflow=0, wr_ptr_gray=5'b00000, mem_we=0. First edge after release -> full=0.
- Fill (rd_ptr_gray held 0): wr_en=1 with din 1..16 on consecutive edges ->
  - mem_waddr 0..15 with mem_we=1, and wr_ack high 16 cycles.
  - almost_full=1 after the 14th accepted edge; full=1 after the 16th.
  - wr_ptr_gray=5'b11000.
- Overflow: 17th write (din=17) while full -> mem_we=0, overflow=1 for exactly one cycle, wr_ptr_gray unchanged, wr_ack=0.
- Drain visibility: set rd_ptr_gray=5'b00110 (bin 4) ->
  - full drops exactly 3 edges later (SYNC_STAGES=2).
  - almost_full=0 (occupancy 12).
  - wr_data_count=12 when WR_DATA_COUNT_EN is defined.
- Wrap: continuous write for 40 words with a model reader keeping occupancy <= 8 ->
  - mem_waddr wraps 15->0 twice.
  - Each wr_ptr_gray change flips one bit.
  - overflow never asserts; full never asserts.
- Reset mid-burst: assert rst after 5 writes -> all outputs to reset values in the same cycle; after release, the next write lands at mem_waddr=0.

Source files
------------

// File: rtl/async_fifo_wr_ctrl.sv
// async_fifo_wr_ctrl: write-domain controller of the dual-clock FIFO.
// Drives the external RAM write port and publishes a registered Gray write
// pointer to the read domain. The read domain's Gray pointer is brought into
// wr_clk through SYNC_STAGES flops and compared against the next write
// pointer to produce conservative full / almost_full flags.
// Optional build macro: WR_DATA_COUNT_EN adds the wr_data_count output.
module async_fifo_wr_ctrl #(
   parameter int DATA_WIDTH         = 8,
   parameter int ADDR_WIDTH         = 4,
   parameter int SYNC_STAGES        = 2,
   parameter int ALMOST_FULL_THRESH = 14
) (
   input  logic                  wr_clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  full,
   output logic                  almost_full,
   output logic                  wr_ack,
   output logic                  overflow,
   input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
   output logic [ADDR_WIDTH:0]   wr_ptr_gray,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_waddr,
   output logic [DATA_WIDTH-1:0] mem_wdata
`ifdef WR_DATA_COUNT_EN
   ,
   output logic [ADDR_WIDTH:0]   wr_data_count
`endif
);

   localparam logic [ADDR_WIDTH:0] AF_TH = (ADDR_WIDTH+1)'(ALMOST_FULL_THRESH);

   function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
      logic [ADDR_WIDTH:0] b;
      b[ADDR_WIDTH] = g[ADDR_WIDTH];
      for (int i = ADDR_WIDTH-1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   logic [ADDR_WIDTH:0]                  wr_bin;
   logic [SYNC_STAGES-1:0][ADDR_WIDTH:0] rq_sync;
   logic [ADDR_WIDTH:0]                  rq_gray, rq_bin;
   logic [ADDR_WIDTH:0]                  next_wr_bin, next_wr_gray;
   logic [ADDR_WIDTH:0]                  full_gray, occ_next;
   logic                                 accept;

   // Full gates acceptance; during reset full is 1 so nothing is written.
   assign accept    = wr_en & ~full;
   assign mem_we    = accept;
   assign mem_waddr = wr_bin[ADDR_WIDTH-1:0];
   assign mem_wdata = din;

   assign rq_gray      = rq_sync[SYNC_STAGES-1];
   assign rq_bin       = gray2bin(rq_gray);
   assign next_wr_bin  = wr_bin + {{ADDR_WIDTH{1'b0}}, accept};
   assign next_wr_gray = next_wr_bin ^ (next_wr_bin >> 1);
   // Full when write is exactly one lap ahead of read: in Gray that is the
   // read pointer with its two MSBs inverted.
   assign full_gray    = {~rq_gray[ADDR_WIDTH:ADDR_WIDTH-1], rq_gray[ADDR_WIDTH-2:0]};
   assign occ_next     = next_wr_bin - rq_bin;

   // Read pointer synchronizer: shift chain, newest sample at index 0.
   always_ff @(posedge wr_clk or posedge rst) begin
      if (rst) rq_sync <= '0;
      else     rq_sync <= {rq_sync[SYNC_STAGES-2:0], rd_ptr_gray};
   end

   // Write pointer in binary and registered Gray form.
   always_ff @(posedge wr_clk or posedge rst) begin
      if (rst) begin
         wr_bin      <= '0;
         wr_ptr_gray <= '0;
      end else begin
         wr_bin      <= next_wr_bin;
         wr_ptr_gray <= next_wr_gray;
      end
   end

   // Status flags, evaluated against the next pointer so the filling write
   // raises full on the same edge.
   always_ff @(posedge wr_clk or posedge rst) begin
      if (rst) begin
         full        <= 1'b1;
         almost_full <= 1'b0;
         wr_ack      <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         full        <= (next_wr_gray == full_gray);
         almost_full <= (occ_next >= AF_TH);
         wr_ack      <= accept;
         overflow    <= wr_en & full;
      end
   end

`ifdef WR_DATA_COUNT_EN
   // Occupancy as seen from the write side, same lag as almost_full.
   always_ff @(posedge wr_clk or posedge rst) begin
      if (rst) wr_data_count <= '0;
      else     wr_data_count <= occ_next;
   end
`endif

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// tb_async_fifo_wr_ctrl: randomized bench for the FIFO write controller.
// The reference model tracks words written and read as plain integers; the
// read pointer seen by the write side is delayed through a queue of samples.
module tb_async_fifo_wr_ctrl;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int SS = 2;
   localparam int AF = 14;
   localparam int DEPTH = 1 << AW;
   localparam int PMOD  = 1 << (AW+1);

   logic          wr_clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [DW-1:0] din = '0;
   logic          full, almost_full, wr_ack, overflow;
   logic [AW:0]   rd_ptr_gray = '0;
   logic [AW:0]   wr_ptr_gray;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;
`ifdef WR_DATA_COUNT_EN
   logic [AW:0]   wr_data_count;
`endif

   async_fifo_wr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(SS),
                        .ALMOST_FULL_THRESH(AF)) dut (
      .wr_clk(wr_clk), .rst(rst), .wr_en(wr_en), .din(din),
      .full(full), .almost_full(almost_full), .wr_ack(wr_ack), .overflow(overflow),
      .rd_ptr_gray(rd_ptr_gray), .wr_ptr_gray(wr_ptr_gray),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
`ifdef WR_DATA_COUNT_EN
      , .wr_data_count(wr_data_count)
`endif
   );

   always #5 wr_clk = ~wr_clk;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int m_w;        // words accepted since reset
   int m_rd;       // words read since reset (reader model)
   int m_occ;
   logic m_full, m_af, m_ack, m_ovf;
   int rq_q[$];    // read pointer samples in flight through the synchronizer

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [AW:0] gray(input int b);
      int m;
      m = b % PMOD;
      return (AW+1)'(m ^ (m >> 1));
   endfunction

   task automatic model_reset();
      m_w = 0; m_rd = 0; m_occ = 0;
      m_full = 1'b1; m_af = 1'b0; m_ack = 1'b0; m_ovf = 1'b0;
      rq_q.delete();
      for (int i = 0; i < SS; i++) rq_q.push_back(0);
   endtask

   task automatic check_regs(input string pfx);
      chk({pfx, "full"},        int'(full),        int'(m_full));
      chk({pfx, "almost_full"}, int'(almost_full), int'(m_af));
      chk({pfx, "wr_ack"},      int'(wr_ack),      int'(m_ack));
      chk({pfx, "overflow"},    int'(overflow),    int'(m_ovf));
      chk({pfx, "wr_ptr_gray"}, int'(wr_ptr_gray), int'(gray(m_w)));
`ifdef WR_DATA_COUNT_EN
      chk({pfx, "wr_data_count"}, int'(wr_data_count), m_occ);
`endif
   endtask

   // One wr_clk cycle: drive, check RAM port before the edge, advance the
   // model on the edge, check registered outputs just after it.
   task automatic step(input logic we, input logic [DW-1:0] d, input int rdv);
      logic acc;
      int   rq;
      wr_en = we; din = d; rd_ptr_gray = gray(rdv);
      @(negedge wr_clk);
      acc = we && !m_full;
      chk("mem_we", int'(mem_we), int'(acc));
      if (acc) begin
         chk("mem_waddr", int'(mem_waddr), m_w % DEPTH);
         chk("mem_wdata", int'(mem_wdata), int'(d));
      end
      @(posedge wr_clk);
      rq = rq_q.pop_front();
      rq_q.push_back(rdv);
      m_ack = acc;
      m_ovf = we && m_full;
      if (acc) m_w++;
      m_occ  = (m_w - rq) % PMOD;
      m_full = (m_occ == DEPTH);
      m_af   = (m_occ >= AF);
      #1;
      check_regs("");
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1; wr_en = 1'b0; rd_ptr_gray = '0;
      repeat (n) @(posedge wr_clk);
      #1;
      model_reset();
      check_regs("rst_");
      chk("rst_mem_we", int'(mem_we), 0);
      rst = 1'b0;
   endtask

   initial begin
      int k, wraps, a, ovf_seen, full_seen;
      logic [AW:0] pg;

      // Reset and release; first edge clears full without writing.
      do_reset(6);
      step(1'b0, '0, 0);
      chk("full_after_release", int'(full), 0);

      // Fill with read pointer held at 0.
      for (int i = 1; i <= DEPTH; i++) step(1'b1, DW'(i), 0);
      chk("fill_full", int'(full), 1);
      chk("fill_gray", int'(wr_ptr_gray), 5'b11000);

      // Write while full is rejected.
      step(1'b1, DW'(17), 0);
      chk("ovf_pulse", int'(overflow), 1);
      step(1'b0, '0, 0);
      chk("ovf_single", int'(overflow), 0);

      // Reader jumps to 4: full should drop after the synchronizer lag.
      m_rd = 4;
      k = 0;
      for (int i = 1; i <= 10; i++) begin
         step(1'b0, '0, m_rd);
         if (!full) begin k = i; break; end
      end
      chk("drain_lag", k, SS + 1);
      chk("drain_af", int'(almost_full), 0);

      // Drain fully, then stream 40 words with a reader trailing close behind.
      while (m_rd < m_w) begin m_rd++; step(1'b0, '0, m_rd); end
      repeat (SS + 1) step(1'b0, '0, m_rd);
      wraps = 0; ovf_seen = 0; full_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (m_rd < m_w && ((m_w - m_rd) >= 4 || $urandom_range(0, 1) == 1)) m_rd++;
         a  = int'(mem_waddr);
         pg = wr_ptr_gray;
         step(1'b1, DW'($urandom), m_rd);
         if (a == DEPTH-1 && wr_ack) wraps++;
         chk("gray_1bit", $countones(pg ^ wr_ptr_gray), 1);
         if (overflow) ovf_seen++;
         if (full) full_seen++;
      end
      chk("wraps", wraps, 2);
      chk("wrap_ovf", ovf_seen, 0);
      chk("wrap_full", full_seen, 0);

      // Random traffic with a slow reader so full and overflow get exercised.
      for (int i = 0; i < 150; i++) begin
         if (m_rd < m_w && $urandom_range(0, 3) == 0) m_rd++;
         step($urandom_range(0, 3) != 0, DW'($urandom), m_rd);
      end

      // Reset in the middle of a burst.
      do_reset(2);
      step(1'b0, '0, 0);
      for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h40 + i), 0);
      wr_en = 1'b1; din = 8'hA5;
      @(negedge wr_clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_full", int'(full), 1);
      chk("mid_mem_we", int'(mem_we), 0);
      chk("mid_waddr", int'(mem_waddr), 0);
      chk("mid_gray", int'(wr_ptr_gray), 0);
      chk("mid_ack", int'(wr_ack), 0);
      chk("mid_af", int'(almost_full), 0);
      do_reset(2);
      step(1'b0, '0, 0);
      step(1'b1, 8'h5A, 0);
      chk("post_reset_gray", int'(wr_ptr_gray), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
